// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the multicycle MIPS32 execute stage.
// MULT/MULTU use 32 shift-add steps, DIV/DIVU use 32 restoring-divide steps;
// both run on magnitudes, and the sign is fixed up in the FINISH cycle.
// Optional feature macro: MDU_FAST_MUL_EN (single-cycle combinational multiply).
module mult_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              hi_we,
    input  logic              lo_we,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int unsigned         ACC_W   = 2 * DATA_W;
    localparam logic [5:0]          STEPS   = 6'(DATA_W);
    localparam logic [DATA_W-1:0]   ONE     = DATA_W'(1);
    localparam logic [ACC_W-1:0]    ACC_ONE = ACC_W'(1);

    typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_operand;   // multiplicand for multiply, divisor for divide
    logic [ACC_W-1:0]    r_acc;       // {product-high, multiplier} or {remainder, dividend/quotient}
    logic                r_neg_q;     // negate product / quotient
    logic                r_neg_r;     // negate remainder (dividend was negative)
    logic [5:0]          r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    // Operand conditioning at the start edge; op[0]=1 means unsigned.
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_a_abs;
    logic [DATA_W-1:0]   w_b_abs;
    logic                w_fast;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & src_a[DATA_W-1];
    assign w_b_neg  = w_signed & src_b[DATA_W-1];
    assign w_a_abs  = w_a_neg ? (~src_a + ONE) : src_a;
    assign w_b_abs  = w_b_neg ? (~src_b + ONE) : src_b;

`ifdef MDU_FAST_MUL_EN
    logic [ACC_W-1:0]    w_fast_prod;
    assign w_fast      = ~op[1];
    assign w_fast_prod = {{DATA_W{1'b0}}, w_a_abs} * {{DATA_W{1'b0}}, w_b_abs};
`else
    assign w_fast      = 1'b0;
`endif

    // One shift-add multiply step: add multiplicand to the high half if lsb set, then shift right.
    logic [DATA_W-1:0]   w_addend;
    logic [DATA_W:0]     w_mul_sum;
    logic [ACC_W-1:0]    w_mul_next;

    assign w_addend   = r_acc[0] ? r_operand : '0;
    assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:DATA_W]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // One restoring divide step: shift in next dividend bit, trial-subtract the divisor.
    logic [DATA_W:0]     w_rem;
    logic [DATA_W:0]     w_diff;
    logic [ACC_W-1:0]    w_div_next;

    assign w_rem      = r_acc[ACC_W-1:DATA_W-1];
    assign w_diff     = w_rem - {1'b0, r_operand};
    assign w_div_next = w_diff[DATA_W]
                      ? {w_rem[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                      : {w_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

    // Sign correction applied in the FINISH cycle.
    logic [ACC_W-1:0]    w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rmd;
    logic [DATA_W-1:0]   w_hi_res;
    logic [DATA_W-1:0]   w_lo_res;

    assign w_prod   = r_neg_q ? (~r_acc + ACC_ONE) : r_acc;
    assign w_quo    = r_neg_q ? (~r_acc[DATA_W-1:0] + ONE) : r_acc[DATA_W-1:0];
    assign w_rmd    = r_neg_r ? (~r_acc[ACC_W-1:DATA_W] + ONE) : r_acc[ACC_W-1:DATA_W];
    assign w_hi_res = r_op[1] ? w_rmd : w_prod[ACC_W-1:DATA_W];
    assign w_lo_res = r_op[1] ? w_quo : w_prod[DATA_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_next = w_fast ? StFinish : StCalc;
            StCalc:   if (r_cnt == 6'd1) w_state_next = StFinish;
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO write-back and MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= 2'b00;
            r_operand <= '0;
            r_acc     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_cnt     <= 6'd0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_op      <= op;
                        r_operand <= op[1] ? w_b_abs : w_a_abs;
                        r_acc     <= op[1] ? {{DATA_W{1'b0}}, w_a_abs}
                                           : {{DATA_W{1'b0}}, w_b_abs};
`ifdef MDU_FAST_MUL_EN
                        if (w_fast) r_acc <= w_fast_prod;
`endif
                        // Divide by zero keeps an all-ones quotient regardless of sign.
                        r_neg_q   <= (w_a_neg ^ w_b_neg) & ~(op[1] & (src_b == '0));
                        r_neg_r   <= w_a_neg;
                        r_cnt     <= STEPS;
                    end else begin
                        if (hi_we) r_hi <= src_a;
                        if (lo_we) r_lo <= src_a;
                    end
                end
                StCalc: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - 6'd1;
                end
                StFinish: begin
                    r_hi   <= w_hi_res;
                    r_lo   <= w_lo_res;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != StIdle);
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
